// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller.
// Sits behind the vehicle light controller: grants WALK only inside a
// vehicle-red window, follows it with a flashing clearance countdown, and
// holds DONT_WALK at all other times. All outputs are registered.
module ped_crossing_ctrl #(
  parameter int WALK_TIME  = 8,
  parameter int CLEAR_TIME = 5,
  parameter int FLASH_HALF = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             ped_btn,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending,
  output logic [CNT_W-1:0] countdown,
  output logic             fault
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WALK  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_TIME - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_TIME - 1);
  localparam logic [CNT_W-1:0] CLEAR_DISP = CNT_W'(CLEAR_TIME);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_HALF - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] flash_q, flash_d;
  logic [CNT_W-1:0] cd_q, cd_d;
  logic             walk_q, walk_d;
  logic             dw_q, dw_d;
  logic             pend_q, pend_d;
  logic             fault_q;
  logic             s1_q, s2_q, s3_q;
  logic             red_prev_q;

  logic             legal;
  logic             red_rise;
  logic             btn_edge;

  // Upstream lights must be exactly one-hot to be trusted.
  assign legal    = (({1'b0, red} + {1'b0, yellow} + {1'b0, green}) == 2'd1);
  assign red_rise = red & ~red_prev_q & legal;
  assign btn_edge = s2_q & ~s3_q;

  // Button synchronizer, edge-detect history and red history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      red_prev_q <= 1'b0;
    end else begin
      s1_q       <= ped_btn;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      red_prev_q <= red;
    end
  end

  // Next-state and next-output logic for the crossing sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flash_d = flash_q;
    cd_d    = cd_q;
    walk_d  = walk_q;
    dw_d    = dw_q;
    pend_d  = pend_q | btn_edge;

    if (!legal) begin
      // Untrusted lights override everything; the request is kept.
      state_d = ST_FAULT;
      walk_d  = 1'b0;
      dw_d    = 1'b1;
      cd_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          walk_d = 1'b0;
          dw_d   = 1'b1;
          cd_d   = '0;
          if (red_rise && (pend_q || btn_edge)) begin
            state_d = ST_WALK;
            pend_d  = 1'b0;
            cnt_d   = WALK_LOAD;
            walk_d  = 1'b1;
            dw_d    = 1'b0;
          end
        end
        ST_WALK: begin
          if (!red) begin
            // Vehicles are about to move: abandon the crossing at once.
            state_d = ST_IDLE;
            walk_d  = 1'b0;
            dw_d    = 1'b1;
            cd_d    = '0;
          end else if (cnt_q == '0) begin
            state_d = ST_CLEAR;
            cnt_d   = CLEAR_LOAD;
            flash_d = FLASH_LOAD;
            walk_d  = 1'b0;
            dw_d    = 1'b1;
            cd_d    = CLEAR_DISP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_CLEAR: begin
          if (!red || (cnt_q == '0)) begin
            state_d = ST_IDLE;
            walk_d  = 1'b0;
            dw_d    = 1'b1;
            cd_d    = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
            // Display shows remaining cycles including the current one.
            cd_d  = cnt_q;
            if (flash_q == '0) begin
              dw_d    = ~dw_q;
              flash_d = FLASH_LOAD;
            end else begin
              flash_d = flash_q - 1'b1;
            end
          end
        end
        default: begin
          // FAULT exit: a red rise seen on this cycle is deliberately ignored.
          state_d = ST_IDLE;
          walk_d  = 1'b0;
          dw_d    = 1'b1;
          cd_d    = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      flash_q <= '0;
      cd_q    <= '0;
      walk_q  <= 1'b0;
      dw_q    <= 1'b1;
      pend_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      cd_q    <= cd_d;
      walk_q  <= walk_d;
      dw_q    <= dw_d;
      pend_q  <= pend_d;
      fault_q <= ~legal;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dw_q;
  assign req_pending = pend_q;
  assign countdown   = cd_q;
  assign fault       = fault_q;

endmodule
